// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM states, requester ids, counter sizing.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD_CAP  = 2'd3
  } state_e;

  // Encoding doubles as the bit index into the req/gnt vectors.
  typedef enum logic {
    REQ_WR = 1'b0,
    REQ_RD = 1'b1
  } requester_e;

  // Read latency is limited to 1..7, so the wait counter never needs more than 3 bits.
  localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to whoever was not served last.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       [1:0] req,
  input  requester_e       last_served,
  input  logic             enable,
  output logic       [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_served == REQ_RD) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between a write requester and a read requester using
// req/gnt handshakes, round-robin arbitration and a fixed-latency read capture.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  // Handshake: req is a level held by the requester; gnt is a single-cycle combinational
  // pulse in an IDLE cycle, and address/data are taken at the end of that gnt cycle.

  state_e              state_q, state_d;
  requester_e          last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic [1:0]          gnt;

  // Reset gates the enable so no grant leaks out while the block is held in reset.
  rr_arb2 u_rr_arb2 (
    .req         ({rd_req, wr_req}),
    .last_served (last_q),
    .enable      ((state_q == IDLE) && reset),
    .gnt         (gnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (gnt[REQ_WR]) begin
          state_d = WR;
          addr_d  = wr_addr;
          data_d  = wr_data;
          last_d  = REQ_WR;
        end else if (gnt[REQ_RD]) begin
          state_d = RD_WAIT;
          addr_d  = rd_addr;
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          last_d  = REQ_RD;
        end
      end
      WR: state_d = IDLE;
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_CAP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= REQ_RD;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_valid_q <= (state_q == RD_CAP);
      if (state_q == RD_CAP) rd_data_q <= ram_q;
    end
  end

  // Write strobe is decoded from the state register so reset removes it at once.
  assign ram_wren    = (state_q == WR);
  assign wr_done     = (state_q == WR);
  assign wr_gnt      = gnt[REQ_WR];
  assign rd_gnt      = gnt[REQ_RD];
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at read latency 2 with a RAM model,
// one at read latency 1 in front of an address-derived ROM.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        wr_req, rd_req, wr_gnt, rd_gnt, wr_done, rd_valid, ram_wren, busy;
  logic [15:0] wr_addr, rd_addr, ram_address;
  logic [31:0] wr_data, rd_data, ram_data, ram_q;
  logic [1:0]  dbg_state;

  logic        wr_req1, rd_req1, wr_gnt1, rd_gnt1, wr_done1, rd_valid1, ram_wren1, busy1;
  logic [15:0] wr_addr1, rd_addr1, ram_address1;
  logic [31:0] wr_data1, rd_data1, ram_data1, ram_q1;
  logic [1:0]  dbg_state1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_gnt(wr_gnt1), .wr_done(wr_done1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_gnt(rd_gnt1), .rd_valid(rd_valid1), .rd_data(rd_data1),
    .ram_address(ram_address1), .ram_data(ram_data1), .ram_wren(ram_wren1), .ram_q(ram_q1),
    .busy(busy1), .dbg_state_o(dbg_state1)
  );

  // ---------------- RAM models ----------------
  logic [31:0] mem [0:65535];
  logic [31:0] pipe [0:1];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    pipe[0] <= mem[ram_address];
    pipe[1] <= pipe[0];
  end
  assign ram_q = pipe[1];

  // Latency-1 ROM: word = {addr, ~addr}
  logic [31:0] rom_q;
  always @(posedge clk) rom_q <= {ram_address1, ~ram_address1};
  assign ram_q1 = rom_q;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  int          bad, c, ng, k, nv;
  logic        seq [0:3];
  int          gcyc [0:3];
  int          vcyc [0:3];
  logic [15:0] next_addr;
  logic [31:0] exp_w;

  initial begin
    reset = 1'b0;
    wr_req = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    wr_req1 = 0; rd_req1 = 0; wr_addr1 = '0; rd_addr1 = '0; wr_data1 = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wren", ram_wren, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_addr", ram_address, 0);
    check("rst_state", dbg_state, 0);

    // Idle after release: nothing moves for 20 cycles
    @(negedge clk); reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ram_wren || busy || wr_gnt || rd_gnt || wr_done || rd_valid || ram_data != 0) bad++;
      @(negedge clk);
    end
    check("idle_quiet", bad, 0);

    // Single write 5 <= DEADBEEF
    wr_req = 1; wr_addr = 16'h0005; wr_data = 32'hDEADBEEF;
    #1;
    check("wr_gnt_T", wr_gnt, 1);
    check("wr_rdgnt_T", rd_gnt, 0);
    @(negedge clk); wr_req = 0; #1;
    check("wr_wren_T1", ram_wren, 1);
    check("wr_done_T1", wr_done, 1);
    check("wr_addr_T1", ram_address, 16'h0005);
    check("wr_data_T1", ram_data, 32'hDEADBEEF);
    check("wr_state_T1", dbg_state, 1);
    @(negedge clk); #1;
    check("wr_busy_T2", busy, 0);
    check("wr_wren_T2", ram_wren, 0);
    check("wr_hold_addr", ram_address, 16'h0005);

    // Read-after-write of address 5
    @(negedge clk); rd_req = 1; rd_addr = 16'h0005; #1;
    check("rd_gnt_T", rd_gnt, 1);
    @(negedge clk); rd_req = 0; #1;
    check("rd_addr_T1", ram_address, 16'h0005);
    check("rd_state_T1", dbg_state, 2);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      if (rd_valid) bad++;
      @(negedge clk); #1;
    end
    if (rd_valid) bad++;
    check("rd_early_valid", bad, 0);
    @(negedge clk); #1;
    check("rd_valid_T4", rd_valid, 1);
    check("rd_data_T4", rd_data, 32'hDEADBEEF);
    check("rd_busy_T4", busy, 0);
    @(negedge clk); #1;
    check("rd_valid_T5", rd_valid, 0);
    check("rd_data_hold", rd_data, 32'hDEADBEEF);

    // Both requesters held: grants alternate WR,RD,WR,RD at cycles 0,2,6,8
    @(negedge clk);
    wr_req = 1; wr_addr = 16'h000A; wr_data = 32'h1111_1111;
    rd_req = 1; rd_addr = 16'h0005;
    ng = 0; c = 0; bad = 0;
    while (ng < 4 && c < 20) begin
      #1;
      if (wr_gnt && rd_gnt) bad++;
      if (wr_gnt || rd_gnt) begin
        seq[ng] = rd_gnt; gcyc[ng] = c; ng++;
      end
      if (ng < 4) begin @(negedge clk); c++; end
    end
    check("rr_ngrants", ng, 4);
    check("rr_both_gnt", bad, 0);
    if (ng == 4) begin
      check("rr_seq0", seq[0], 0);
      check("rr_seq1", seq[1], 1);
      check("rr_seq2", seq[2], 0);
      check("rr_seq3", seq[3], 1);
      check("rr_cyc1", gcyc[1], 2);
      check("rr_cyc2", gcyc[2], 6);
      check("rr_cyc3", gcyc[3], 8);
    end
    @(negedge clk); wr_req = 0; rd_req = 0; #1;
    k = 0;
    while (busy && k < 10) begin @(negedge clk); #1; k++; end
    check("rr_drain", busy, 0);
    check("rr_rd_data", rd_data, 32'hDEADBEEF);

    // Reset during RD_WAIT, rd_req held throughout
    @(negedge clk); rd_req = 1; rd_addr = 16'h000A; #1;
    check("rst_rd_gnt", rd_gnt, 1);
    @(negedge clk); #1;
    check("rst_in_wait", dbg_state, 2);
    @(negedge clk); reset = 1'b0; #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_data", rd_data, 0);
    check("rst_mid_addr", ram_address, 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rd_valid || rd_gnt || wr_gnt) bad++;
      @(negedge clk); #1;
    end
    check("rst_mid_quiet", bad, 0);
    reset = 1'b1; #1;
    check("rst_rel_gnt", rd_gnt, 1);
    @(negedge clk); rd_req = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rel_valid", rd_valid, 1);
    check("rst_rel_data", rd_data, 32'h1111_1111);

    // Latency-1 instance: back-to-back reads of 0..3, scoreboard-ordered
    @(negedge clk);
    rd_req1 = 1; rd_addr1 = 16'h0000; next_addr = 16'h0000;
    ng = 0; nv = 0; c = 0; bad = 0;
    while (nv < 4 && c < 30) begin
      #1;
      if (ram_wren1) bad++;
      if (rd_valid1) begin
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("l1_data", rd_data1, exp_w);
        end else begin
          check("l1_unexpected_valid", rd_valid1, 0);
        end
        vcyc[nv] = c; nv++;
      end
      if (rd_gnt1 && ng < 4) begin
        exp_q.push_back({rd_addr1, ~rd_addr1});
        gcyc[ng] = c; ng++;
        next_addr = rd_addr1 + 16'd1;
      end
      @(negedge clk); c++;
      rd_addr1 = next_addr;
      if (ng == 4) rd_req1 = 0;
    end
    check("l1_nvalid", nv, 4);
    check("l1_wren", bad, 0);
    if (nv == 4) begin
      check("l1_v0", vcyc[0], 3);
      check("l1_v1", vcyc[1], 6);
      check("l1_v2", vcyc[2], 9);
      check("l1_v3", vcyc[3], 12);
    end
    check("l1_last_word", rd_data1, 32'h0003FFFC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Sequences and shares the single-port 32x(2^16) data RAM between two requesters: the button-driven write requester and the periodic address-scan read requester.
- Replaces the static address/data mux in front of the RAM with req/gnt handshakes and round-robin arbitration.
- Generates ram_address, ram_data and ram_wren, and returns read data with a valid pulse.
- Sits between the requesters and the RAM instance in the top-level memory subsystem.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 32, RAM word width
RD_LATENCY, 2, clock cycles from ram_address registered to ram_q valid (1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
wr_req  input  1  write request, level; held until wr_gnt
wr_addr  input  ADDR_W  write address, sampled in wr_gnt cycle
wr_data  input  DATA_W  write data, sampled in wr_gnt cycle
wr_gnt  output  1  one-cycle pulse: write accepted
wr_done  output  1  one-cycle pulse: RAM write performed
rd_req  input  1  read request, level; held until rd_gnt
rd_addr  input  ADDR_W  read address, sampled in rd_gnt cycle
rd_gnt  output  1  one-cycle pulse: read accepted
rd_valid  output  1  one-cycle pulse: rd_data valid
rd_data  output  DATA_W  last read word, held between reads
ram_address  output  ADDR_W  registered RAM address
ram_data  output  DATA_W  registered RAM write data
ram_wren  output  1  RAM write enable
ram_q  input  DATA_W  RAM read data
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; rd_data=0; rd counter=0; last_served=RD, so the first tie goes to the writer.
- FSM states: IDLE, WR, RD_WAIT, RD_CAP.
- IDLE, in grant cycle T:
  - If exactly one request is high, grant it.
  - If both are high, grant the one not equal to last_served.
  - The gnt pulse is combinational in cycle T.
  - Address (and data for a write) are registered at the end of T; last_served is updated.
- Write service:
  - T+1: state WR, ram_wren=1, wr_done=1.
  - T+2: IDLE; ram_wren=0.
  - Throughput: at most one access per 2 cycles.
- Read service:
  - T+1: ram_address=rd_addr; state RD_WAIT; counter loaded with RD_LATENCY-1.
  - RD_WAIT decrements each cycle; at counter 0 go to RD_CAP.
  - In RD_CAP, ram_q is registered into rd_data.
  - rd_valid=1 in cycle T+2+RD_LATENCY, which is the first IDLE cycle.
  - A new grant may coincide with rd_valid.
- No grant is issued while state != IDLE. Requests that drop before their gnt are ignored.
- ram_address and ram_data hold their last values when idle. ram_wren is 1 only in WR.
- Fairness: with both requesters continuously asserting, grants alternate strictly. Maximum wait for a pending request is (2+RD_LATENCY)+1 cycles.
- Read-after-write to the same address, granted later, returns the newly written data. There is no bypass path; ordering is by grant.
- Reset asserted mid-operation:
  - ram_wren drops immediately.
  - Pending wr_done/rd_valid are not generated.
  - rd_data is cleared.
- Requester obligation: a requester must not re-assert req in the cycle after its own gnt unless it has a new transaction. The arbiter treats any req high in IDLE as new.

Decomposition:
- Package ram_arb_pkg:
  - state_e enum {IDLE, WR, RD_WAIT, RD_CAP}
  - requester_e enum {REQ_WR, REQ_RD}
  - Localparam for the counter width, derived from RD_LATENCY max 7 (3 bits).
- Sub-module rr_arb2: combinational 2-way round-robin.
  - Inputs: req[1:0], last_served, enable.
  - Output: one-hot gnt[1:0].
- FSM, counter and datapath registers stay in ram_port_arbiter.

Test Plan:
- Reset release, no requests -> all outputs 0, busy=0, ram_wren never 1 for 20 cycles.
- Single write wr_addr=16'h0005, wr_data=32'hDEADBEEF -> wr_gnt at T; T+1 ram_wren=1, ram_address=5, ram_data=DEADBEEF, wr_done=1; T+2 busy=0.
- Read of address 5 after that write (RAM behavioural model, RD_LATENCY=2) -> rd_gnt at T, rd_valid=1 at T+4, rd_data=32'hDEADBEEF held afterwards.
- wr_req and rd_req both held high from the same cycle after reset -> grant order WR,RD,WR,RD; the writer wins first; no cycle has both gnts high.
- Reset pulled low during RD_WAIT -> immediately busy=0 and rd_data=0; no rd_valid; after release, the held rd_req is granted on the first IDLE cycle.
- RD_LATENCY=1 build, back-to-back reads of addresses 0..3 with rd_req held -> rd_valid every 3 cycles with the correct words, ram_wren stays 0.
